// File: rtl/idma_axis_loopback_pkg.sv
// idma_axis_loopback_pkg: transform modes, default 64-bit AXI-Stream channel types
// and the data transform shared by the loopback.
package idma_axis_loopback_pkg;

    localparam int unsigned MaxDataWidth = 512;

    typedef logic [MaxDataWidth-1:0] wide_t;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_INV   = 2'd1,
        MODE_BSWAP = 2'd2,
        MODE_INC   = 2'd3
    } mode_e;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [7:0]  user;
    } axis_t_chan_64_t;

    typedef struct packed {
        axis_t_chan_64_t t;
        logic            tvalid;
    } axis_req_64_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_64_t;

    // Works on a zero-extended word; the caller truncates back to its own width,
    // which also gives the modulo wrap for increment and drops inverted upper bits.
    function automatic wide_t transform(input mode_e mode, input wide_t data, input int unsigned nbytes);
        wide_t res;
        res = data;
        if (mode == MODE_INV) res = ~data;
        else if (mode == MODE_INC) res = data + 1'b1;
        else if (mode == MODE_BSWAP) begin
            res = '0;
            for (int unsigned i = 0; i < MaxDataWidth / 8; i++)
                if (i < nbytes) res[8*i +: 8] = data[8*(nbytes-1-i) +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/idma_axis_loopback_fifo.sv
// idma_axis_loopback_fifo: power-of-two FIFO holding whole T-channel beats
// (data, tlast, sideband) with occupancy-derived full/empty flags.
module idma_axis_loopback_fifo #(
    parameter int unsigned Depth = 16,
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AddrWidth = $clog2(Depth);

    entry_t mem [Depth];
    logic [AddrWidth-1:0] wptr, rptr;
    logic [AddrWidth:0] count;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + {{AddrWidth{1'b0}}, push} - {{AddrWidth{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = count == (AddrWidth+1)'(Depth);
    assign empty = count == '0;

endmodule

// File: rtl/idma_axis_loopback.sv
// idma_axis_loopback: AXI-Stream loopback applying a per-packet data transform,
// buffered in cut-through or store-and-forward mode, with egress statistics.
module idma_axis_loopback
    import idma_axis_loopback_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth = 16,
    parameter int unsigned CntWidth = 32,
    parameter type axis_req_t = axis_req_64_t,
    parameter type axis_rsp_t = axis_rsp_64_t,
    parameter type axis_t_chan_t = axis_t_chan_64_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          mode_i,
    input  logic                store_fwd_i,
    input  axis_req_t           rx_req_i,
    output axis_rsp_t           rx_rsp_o,
    output axis_req_t           tx_req_o,
    input  axis_rsp_t           tx_rsp_i,
    output logic [CntWidth-1:0] beats_o,
    output logic [CntWidth-1:0] pkts_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                overflow_o
);

    localparam int unsigned PktWidth = $clog2(Depth) + 1;

    logic full, empty, push, pop, tvalid, rx_ready;
    logic in_pkt, sf_q, overflow_q, pkt_in, pkt_out;
    mode_e mode_q, cur_mode;
    logic [PktWidth-1:0] pkt_cnt;
    logic [CntWidth-1:0] beats_q, pkts_q;
    axis_t_chan_t t_in, t_out;

    always_comb begin
        cur_mode  = in_pkt ? mode_q : mode_e'(mode_i);
        t_in      = rx_req_i.t;
        t_in.data = DataWidth'(transform(cur_mode, wide_t'(rx_req_i.t.data), DataWidth / 8));
    end

    // A full buffer without a complete packet is released so the stream cannot deadlock.
    always_comb begin
        tvalid          = !empty && (!sf_q || pkt_cnt != '0 || full);
        pop             = tvalid && tx_rsp_i.tready;
        rx_ready        = rst_ni && (!full || pop);
        push            = rx_req_i.tvalid && rx_ready;
        pkt_in          = push && rx_req_i.t.last;
        pkt_out         = pop && t_out.last;
        rx_rsp_o        = '0;
        rx_rsp_o.tready = rx_ready;
        tx_req_o        = '0;
        tx_req_o.t      = t_out;
        tx_req_o.tvalid = tvalid;
    end

    idma_axis_loopback_fifo #(
        .Depth   (Depth),
        .entry_t (axis_t_chan_t)
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wdata  (t_in),
        .rdata  (t_out),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_pkt     <= 1'b0;
            mode_q     <= MODE_PASS;
            sf_q       <= 1'b0;
            overflow_q <= 1'b0;
            pkt_cnt    <= '0;
            beats_q    <= '0;
            pkts_q     <= '0;
        end else begin
            sf_q <= store_fwd_i;
            if (push) begin
                in_pkt <= !rx_req_i.t.last;
                if (!in_pkt) mode_q <= mode_e'(mode_i);
            end
            if (sf_q && full && pkt_cnt == '0) overflow_q <= 1'b1;
            if (pkt_in != pkt_out) pkt_cnt <= pkt_in ? pkt_cnt + 1'b1 : pkt_cnt - 1'b1;
            if (pop) begin
                beats_q <= beats_q + 1'b1;
                if (t_out.last) pkts_q <= pkts_q + 1'b1;
            end
        end
    end

    assign beats_o    = beats_q;
    assign pkts_o     = pkts_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_idma_axis_loopback.sv
// tb_idma_axis_loopback: directed stimulus with a queue scoreboard; a negedge monitor
// checks egress order, stall stability and full/empty against a modelled occupancy.
module tb_idma_axis_loopback;
    import idma_axis_loopback_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic store_fwd = 1'b0;
    axis_req_64_t rx_req, tx_req;
    axis_rsp_64_t rx_rsp, tx_rsp;
    logic [31:0] beats, pkts;
    logic full, empty, overflow;
    logic tx_ready_man = 1'b0;
    logic rnd_bit = 1'b0;
    logic rand_en = 1'b0;
    int checks = 0;
    int errors = 0;
    int occ = 0;
    logic stall = 1'b0;
    axis_t_chan_64_t held;
    axis_t_chan_64_t exp_q[$];

    always #5 clk = ~clk;

    assign tx_rsp.tready = rand_en ? rnd_bit : tx_ready_man;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    idma_axis_loopback #(
        .DataWidth     (64),
        .Depth         (16),
        .CntWidth      (32),
        .axis_req_t    (axis_req_64_t),
        .axis_rsp_t    (axis_rsp_64_t),
        .axis_t_chan_t (axis_t_chan_64_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mode_i      (mode),
        .store_fwd_i (store_fwd),
        .rx_req_i    (rx_req),
        .rx_rsp_o    (rx_rsp),
        .tx_req_o    (tx_req),
        .tx_rsp_i    (tx_rsp),
        .beats_o     (beats),
        .pkts_o      (pkts),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic axis_t_chan_64_t mk(input logic [63:0] d, input logic l);
        axis_t_chan_64_t t;
        t.data = d;
        t.strb = 8'hF0;
        t.keep = 8'hFF;
        t.last = l;
        t.id   = d[3:0];
        t.dest = 4'h5;
        t.user = d[11:4];
        return t;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat, records its expected egress form when the handshake is seen.
    task automatic send(input logic [63:0] d, input logic l, input logic [63:0] e);
        axis_t_chan_64_t t;
        int n;
        if (clk == 1'b0) sync();
        t = mk(d, l);
        rx_req.t = t;
        rx_req.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_rsp.tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_rsp.tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%b required 1", rx_rsp.tready);
        end else begin
            t.data = e;
            exp_q.push_back(t);
        end
        sync();
        rx_req.tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        axis_t_chan_64_t e;
        if (rst_n) begin
            checks++;
            if (empty !== (occ == 0) || full !== (occ == 16)) begin
                errors++;
                $display("FAIL occupancy: empty=%b full=%b required occupancy %0d", empty, full, occ);
            end
            if (stall) begin
                checks++;
                if (!tx_req.tvalid || tx_req.t !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b t=%h required valid=1 t=%h", tx_req.tvalid, tx_req.t, held);
                end
            end
            if (tx_req.tvalid && tx_rsp.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL egress_extra: got t=%h required no beat", tx_req.t);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_req.t !== e) begin
                        errors++;
                        $display("FAIL egress: got t=%h required t=%h", tx_req.t, e);
                    end
                end
            end
            stall = tx_req.tvalid && !tx_rsp.tready;
            held = tx_req.t;
            occ = occ + ((rx_req.tvalid && rx_rsp.tready) ? 1 : 0) - ((tx_req.tvalid && tx_rsp.tready) ? 1 : 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] b0, p0;
        logic [63:0] d;
        rx_req = '0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 64'(rx_rsp.tready), 64'd0);
        check("rst_tx_valid", 64'(tx_req.tvalid), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_beats", 64'(beats), 64'd0);
        check("rst_pkts", 64'(pkts), 64'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(rx_rsp.tready), 64'd1);

        // Cut-through pass-through packet of 16 beats.
        sync();
        tx_ready_man = 1'b1;
        for (int i = 1; i <= 16; i++) send(64'(i), i == 16, 64'(i));
        drain(200);
        check("ct_beats", 64'(beats), 64'd16);
        check("ct_pkts", 64'(pkts), 64'd1);

        // Transforms, then a mid-packet mode change that must be ignored.
        sync();
        mode = 2'd1;
        send(64'h1, 1'b1, 64'hFFFFFFFFFFFFFFFE);
        mode = 2'd2;
        send(64'h1, 1'b1, 64'h0100000000000000);
        mode = 2'd3;
        send(64'h1, 1'b1, 64'h2);
        send(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0);
        mode = 2'd1;
        send(64'h1234, 1'b0, 64'hFFFFFFFFFFFFEDCB);
        mode = 2'd0;
        send(64'h55, 1'b1, 64'hFFFFFFFFFFFFFFAA);
        send(64'h77, 1'b1, 64'h77);
        drain(200);

        // Store-and-forward: nothing leaves until the tlast beat is in.
        sync();
        store_fwd = 1'b1;
        tx_ready_man = 1'b0;
        repeat (2) sync();
        for (int i = 1; i <= 8; i++) begin
            send(64'(100 + i), i == 8, 64'(100 + i));
            @(negedge clk);
            check("sf_tvalid", 64'(tx_req.tvalid), (i == 8) ? 64'd1 : 64'd0);
        end
        sync();
        tx_ready_man = 1'b1;
        drain(200);

        // Store-and-forward overflow with 20 beats and no tlast.
        sync();
        tx_ready_man = 1'b0;
        b0 = beats;
        for (int i = 0; i < 16; i++) send(64'(200 + i), 1'b0, 64'(200 + i));
        @(negedge clk);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_release_valid", 64'(tx_req.tvalid), 64'd1);
        @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
        sync();
        tx_ready_man = 1'b1;
        for (int i = 16; i < 20; i++) send(64'(200 + i), 1'b0, 64'(200 + i));
        store_fwd = 1'b0;
        drain(200);
        check("ovf_beats", 64'(beats - b0), 64'd20);
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_empty", 64'(empty), 64'd1);

        // Random egress backpressure over 100 beats.
        sync();
        rand_en = 1'b1;
        b0 = beats;
        p0 = pkts;
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom};
            send(d, (i % 10) == 9, d);
        end
        drain(2000);
        check("bp_beats", 64'(beats - b0), 64'd100);
        check("bp_pkts", 64'(pkts - p0), 64'd10);
        sync();
        rand_en = 1'b0;
        tx_ready_man = 1'b0;

        // Reset in the middle of a packet discards it and clears the captured mode.
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            send(64'(300 + i), 1'b0, ~64'(300 + i));
            if (i == 2) mode = 2'd3;
        end
        rst_n = 1'b0;
        exp_q.delete();
        occ = 0;
        stall = 1'b0;
        #1;
        check("mid_rst_empty", 64'(empty), 64'd1);
        check("mid_rst_full", 64'(full), 64'd0);
        check("mid_rst_beats", 64'(beats), 64'd0);
        check("mid_rst_pkts", 64'(pkts), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        sync();
        rst_n = 1'b1;
        tx_ready_man = 1'b1;
        for (int i = 0; i < 3; i++) send(64'(400 + i), i == 2, 64'(401 + i));
        drain(200);
        check("post_rst_beats", 64'(beats), 64'd3);
        check("post_rst_pkts", 64'(pkts), 64'd1);
        check("post_rst_empty", 64'(empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
